// File: rtl/systolic_collector.sv
// Collects the four skewed lanes of a 4x4 systolic array on a diagonal wavefront into
// a 4x4 result matrix, then drains that matrix row by row over a valid/ready handshake.
module systolic_collector #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] q1_i,
    input  logic [WIDTH-1:0] q2_i,
    input  logic [WIDTH-1:0] q3_i,
    input  logic [WIDTH-1:0] q4_i,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             out_valid_o,
    output logic [1:0]       out_row_o,
    output logic [WIDTH-1:0] o1_o,
    output logic [WIDTH-1:0] o2_o,
    output logic [WIDTH-1:0] o3_o,
    output logic [WIDTH-1:0] o4_o,
    output logic [WIDTH-1:0] m11_o,
    output logic [WIDTH-1:0] m12_o,
    output logic [WIDTH-1:0] m13_o,
    output logic [WIDTH-1:0] m14_o,
    output logic [WIDTH-1:0] m21_o,
    output logic [WIDTH-1:0] m22_o,
    output logic [WIDTH-1:0] m23_o,
    output logic [WIDTH-1:0] m24_o,
    output logic [WIDTH-1:0] m31_o,
    output logic [WIDTH-1:0] m32_o,
    output logic [WIDTH-1:0] m33_o,
    output logic [WIDTH-1:0] m34_o,
    output logic [WIDTH-1:0] m41_o,
    output logic [WIDTH-1:0] m42_o,
    output logic [WIDTH-1:0] m43_o,
    output logic [WIDTH-1:0] m44_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t                       state_q;
    logic [2:0]                   cnt_q;
    logic                         busy_q;
    logic                         out_valid_q;
    logic [1:0]                   out_row_q;
    logic                         done_q;
    logic [3:0][3:0][WIDTH-1:0]   mat_q;
    logic [3:0][3:0][WIDTH-1:0]   mat_d;

    logic [3:0][WIDTH-1:0]        lane;
    logic [3:0][WIDTH-1:0]        row_sel;
    logic                         sample_en;
    logic [2:0]                   step;

    assign lane = {q4_i, q3_i, q2_i, q1_i};

    // The start cycle itself samples wave step 0, before cnt has been loaded.
    assign sample_en = (state_q == CAPTURE) || ((state_q == IDLE) && start_i);
    assign step      = (state_q == IDLE) ? 3'd0 : cnt_q;

    always_comb begin
        mat_d = mat_q;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (sample_en && (step == 3'(r + c))) begin
                    mat_d[r][c] = lane[c];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= 2'd0;
            done_q      <= 1'b0;
            mat_q       <= '0;
        end else begin
            mat_q  <= mat_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= CAPTURE;
                        cnt_q   <= 3'd1;
                        busy_q  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (cnt_q == 3'd6) begin
                        state_q     <= DRAIN;
                        cnt_q       <= 3'd0;
                        out_valid_q <= 1'b1;
                        out_row_q   <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (out_row_q == 2'd3) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            out_row_q   <= 2'd0;
                            done_q      <= 1'b1;
                        end else begin
                            out_row_q <= out_row_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Row outputs are a live view of the matrix, forced to zero outside DRAIN.
    assign row_sel = mat_q[out_row_q];
    assign o1_o    = out_valid_q ? row_sel[0] : '0;
    assign o2_o    = out_valid_q ? row_sel[1] : '0;
    assign o3_o    = out_valid_q ? row_sel[2] : '0;
    assign o4_o    = out_valid_q ? row_sel[3] : '0;

    assign busy_o      = busy_q;
    assign out_valid_o = out_valid_q;
    assign out_row_o   = out_row_q;
    assign done_o      = done_q;

    assign m11_o = mat_q[0][0];
    assign m12_o = mat_q[0][1];
    assign m13_o = mat_q[0][2];
    assign m14_o = mat_q[0][3];
    assign m21_o = mat_q[1][0];
    assign m22_o = mat_q[1][1];
    assign m23_o = mat_q[1][2];
    assign m24_o = mat_q[1][3];
    assign m31_o = mat_q[2][0];
    assign m32_o = mat_q[2][1];
    assign m33_o = mat_q[2][2];
    assign m34_o = mat_q[2][3];
    assign m41_o = mat_q[3][0];
    assign m42_o = mat_q[3][1];
    assign m43_o = mat_q[3][2];
    assign m44_o = mat_q[3][3];

endmodule

// File: tb/tb_systolic_collector.sv
// Self-checking bench for systolic_collector: drives diagonal wavefronts from a known
// matrix and compares the assembled matrix, drained rows and handshake timing.
module tb_systolic_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        outReady;
    logic [31:0] lanes [4];
    logic        busy;
    logic        outValid;
    logic [1:0]  outRow;
    logic [31:0] oRow [4];
    logic [31:0] mOut [16];
    logic        done;

    logic [31:0] stim [16];
    logic [31:0] expMat [16];
    int          vectorCount = 0;
    int          missCount = 0;

    always #5 clk = ~clk;

    systolic_collector #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .q1_i(lanes[0]), .q2_i(lanes[1]), .q3_i(lanes[2]), .q4_i(lanes[3]),
        .out_ready_i(outReady), .busy_o(busy), .out_valid_o(outValid), .out_row_o(outRow),
        .o1_o(oRow[0]), .o2_o(oRow[1]), .o3_o(oRow[2]), .o4_o(oRow[3]),
        .m11_o(mOut[0]),  .m12_o(mOut[1]),  .m13_o(mOut[2]),  .m14_o(mOut[3]),
        .m21_o(mOut[4]),  .m22_o(mOut[5]),  .m23_o(mOut[6]),  .m24_o(mOut[7]),
        .m31_o(mOut[8]),  .m32_o(mOut[9]),  .m33_o(mOut[10]), .m34_o(mOut[11]),
        .m41_o(mOut[12]), .m42_o(mOut[13]), .m43_o(mOut[14]), .m44_o(mOut[15]),
        .done_o(done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkMatrix(input string tag);
        for (int i = 0; i < 16; i++) begin
            checkOutput(tag, mOut[i], expMat[i]);
        end
    endtask

    // Caller sits at a negedge; start is raised in this cycle (cycle T).
    // stallMode: 0 = always ready, 1 = three stall cycles at row 1, 2 = random ready.
    // junk == 0 selects random filler on lanes outside the wavefront.
    task automatic applyStimulus(input int stallMode, input bit extraStarts, input logic [31:0] junk);
        int cyc;
        int row;
        int stalls;
        int budget;
        bit rdy;
        cyc = 0;
        for (int c = 0; c < 7; c++) begin
            start = (c == 0) || (extraStarts && c == 3);
            for (int j = 0; j < 4; j++) begin
                int k;
                k = c - j;
                if (k >= 0 && k <= 3) lanes[j] = stim[k * 4 + j];
                else lanes[j] = (junk == 0) ? $urandom : junk;
            end
            if (c >= 1) begin
                checkOutput("busyCapture", {31'd0, busy}, 32'd1);
                checkOutput("validCapture", {31'd0, outValid}, 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        for (int j = 0; j < 4; j++) lanes[j] = $urandom;
        for (int i = 0; i < 16; i++) expMat[i] = stim[i];
        checkMatrix("matrixAtDrain");

        row = 0;
        stalls = 0;
        budget = 0;
        while (row < 4 && budget < 60) begin
            case (stallMode)
                0:       rdy = 1'b1;
                1:       rdy = !(row == 1 && stalls < 3);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            outReady = rdy;
            start = extraStarts && (cyc == 8);
            checkOutput("outValid", {31'd0, outValid}, 32'd1);
            checkOutput("outRow", {30'd0, outRow}, row);
            checkOutput("busyDrain", {31'd0, busy}, 32'd1);
            checkOutput("doneEarly", {31'd0, done}, 32'd0);
            for (int j = 0; j < 4; j++) begin
                checkOutput("rowData", oRow[j], expMat[row * 4 + j]);
            end
            if (rdy) row++;
            else stalls++;
            @(negedge clk);
            cyc++;
            budget++;
        end
        if (row < 4) checkOutput("drainTimeout", row, 4);
        start = 1'b0;
        outReady = 1'b1;
        checkOutput("donePulse", {31'd0, done}, 32'd1);
        checkOutput("busyAfter", {31'd0, busy}, 32'd0);
        checkOutput("validAfter", {31'd0, outValid}, 32'd0);
        checkOutput("doneCycle", cyc, 11 + stalls);
        checkMatrix("matrixHeld");
    endtask

    logic [31:0] floatTab [16] = '{
        32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
        32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
        32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
        32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000
    };

    initial begin
        rst = 1'b1;
        start = 1'b0;
        outReady = 1'b1;
        for (int j = 0; j < 4; j++) lanes[j] = '0;
        for (int i = 0; i < 16; i++) expMat[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        checkMatrix("resetMatrix");
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetValid", {31'd0, outValid}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetRow", {30'd0, outRow}, 32'd0);
        for (int j = 0; j < 4; j++) checkOutput("resetCol", oRow[j], 32'd0);

        // Lane activity without start must not disturb the matrix.
        repeat (5) begin
            for (int j = 0; j < 4; j++) lanes[j] = $urandom;
            @(negedge clk);
        end
        checkMatrix("idleMatrix");
        checkOutput("idleBusy", {31'd0, busy}, 32'd0);

        $display("[TB] identity wave");
        for (int i = 0; i < 16; i++) stim[i] = i;
        applyStimulus(0, 1'b0, 32'hDEADBEEF);
        repeat (2) @(negedge clk);

        $display("[TB] backpressure at row 1");
        applyStimulus(1, 1'b0, 32'hDEADBEEF);
        repeat (3) @(negedge clk);

        $display("[TB] ignored start pulses");
        applyStimulus(0, 1'b1, 32'hDEADBEEF);
        repeat (2) @(negedge clk);

        $display("[TB] reset mid-capture");
        for (int i = 0; i < 16; i++) stim[i] = $urandom;
        for (int c = 0; c < 5; c++) begin
            start = (c == 0);
            for (int j = 0; j < 4; j++) begin
                int k;
                k = c - j;
                lanes[j] = (k >= 0 && k <= 3) ? stim[k * 4 + j] : $urandom;
            end
            if (c == 4) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16; i++) expMat[i] = '0;
        checkMatrix("midResetMatrix");
        checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("midResetValid", {31'd0, outValid}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) stim[i] = floatTab[i];
        applyStimulus(0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        $display("[TB] back-to-back runs");
        for (int i = 0; i < 16; i++) stim[i] = i;
        applyStimulus(0, 1'b0, 32'hDEADBEEF);
        for (int i = 0; i < 16; i++) stim[i] = i + 32'h100;
        applyStimulus(0, 1'b0, 32'hDEADBEEF);

        $display("[TB] randomized runs");
        repeat (8) begin
            for (int i = 0; i < 16; i++) stim[i] = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(2, 1'($urandom_range(0, 1)), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/systolic_collector.md
# systolic_collector

Downstream stage of the dispatcher. It captures the four skewed 32-bit lanes coming out of the 4x4 array on a diagonal wavefront and reassembles them into a 4x4 result matrix. It then drains that matrix row by row to the writeback path over a valid/ready handshake. Data is treated as opaque 32-bit words: the collector never interprets float or integer contents.

## Interface
Parameters:
- WIDTH, 32, lane/element width in bits.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; the wavefront begins on the same cycle.
- q1, q2, q3, q4  input  WIDTH each  skewed lanes; lane j carries column j.
- out_ready  input  1  downstream accepts the current row.
- busy  output  1  high in CAPTURE or DRAIN.
- out_valid  output  1  a row is presented on o1..o4.
- out_row  output  2  index of the presented row (0..3).
- o1, o2, o3, o4  output  WIDTH each  columns 1..4 of the presented row.
- m11..m44  output  WIDTH each  full assembled matrix. 16 ports, row-major, registered.
- done  output  1  one-cycle pulse when the last row is accepted.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- Reset (synchronous): state=IDLE, cnt=0, m11..m44=0, busy=0, out_valid=0, out_row=0, o1..o4=0, done=0. Reset overrides every other input, including mid-CAPTURE or mid-DRAIN. Any partially captured matrix is discarded to zero.
- IDLE -> CAPTURE on start=1:
  - Same cycle: cnt is treated as 0 and wave step 0 is sampled.
  - Registered result: state=CAPTURE, cnt=1.
- Wavefront rule at step c (0..6), for each lane j in 1..4:
  - Row k = c - (j-1).
  - If 0<=k<=3, element m[k+1][j] <= qj. Otherwise lane j is ignored that step.
  - Step 0 writes m11 only. Step 3 writes m41, m32, m23, m14. Step 6 writes m44 only.
  - Each element is written exactly once per run. Elements not yet written keep their previous value; they are not cleared at start.
- CAPTURE: each cycle samples step cnt, then cnt++. After sampling step 6, go to DRAIN with out_row=0.
- DRAIN:
  - out_valid=1. o1..o4 = m[out_row+1][1..4] (combinational from the matrix registers).
  - Beat transfers when out_valid && out_ready. Then out_row++. On the transfer with out_row=3, go to IDLE, pulse done, and set out_row=0.
  - out_ready low holds out_row and o1..o4 stable indefinitely.
- start while busy=1 is ignored: no restart, no queueing.
- start on the same cycle as the final DRAIN transfer is ignored. A new run needs start while in IDLE.
- m11..m44 stay valid and stable from entry into DRAIN until the next run writes them.

## Timing
- start at cycle T. Lanes are sampled at T..T+6 (7 cycles). busy=1 from T+1.
- out_valid first high at T+7. With out_ready tied high, rows transfer at T+7..T+10.
- done pulses for the single cycle T+11, the cycle after the row-3 transfer. busy=0 at T+11.
- Minimum start-to-start spacing is 11 cycles: the earliest restart is start at T+11.
- Each DRAIN stall cycle adds exactly one cycle to done.
- cnt is 3 bits and never exceeds 6. No wrap-around occurs.

## Test plan
- Reset and idle: assert rst 2 cycles. Then check all m=0, busy=0, out_valid=0, done=0. Toggle qj without start: matrix stays 0.
- Identity wave:
  - Stimulus: start at T. At step c, drive lane j with 32'h(row k*4 + j-1) where k=c-(j-1) is valid, and 32'hDEADBEEF where it is invalid.
  - Expected: m11..m44 = 0..F row-major. No DEADBEEF appears anywhere. Rows drain as (0,1,2,3), (4,5,6,7), (8,9,A,B), (C,D,E,F) at T+7..T+10. done at T+11.
- Backpressure:
  - Stimulus: same wave, with out_ready=0 for 3 cycles at row 1.
  - Expected: o1..o4 hold 4,5,6,7 with out_row=1 throughout the stall. done moves to T+14.
- Ignored start: pulse start at T+3 and again during DRAIN. Matrix and timing are identical to the identity-wave run.
- Reset mid-op: assert rst at T+4. Next cycle: state IDLE, m=0, busy=0. A fresh start with float data (m11=32'h00000000 ... m44=32'h41700000, 0.0..15.0) then assembles correctly.
- Back-to-back runs: start a second run at T+11 with values +0x100. All 16 elements update. done pulses at T+22.
